// File: rtl/morse_rx.sv
// Morse receiver: measures mark/gap run lengths on led_in and rebuilds each character
// as an MSB-first code (dash=1, dot=0) plus symbol count; length 0 marks a word space.
module morse_rx #(
  parameter int unsigned UNIT  = 1,
  parameter int unsigned CNT_W = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       led_in,
  output logic       char_vald,
  output logic [7:0] charcode_data,
  output logic [3:0] charlen_data,
  output logic       sym_err
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] MARK    = 2'd1;
  localparam logic [1:0] GAP     = 2'd2;
  localparam logic [1:0] DISCARD = 2'd3;

  localparam logic [CNT_W-1:0] RUN_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] RUN_DASH = CNT_W'(2 * UNIT);
  localparam logic [CNT_W-1:0] RUN_LONG = CNT_W'(5 * UNIT);
  localparam logic [CNT_W-1:0] RUN_SAT  = {CNT_W{1'b1}};

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] run_q, run_d, run_inc;
  logic [3:0]       sym_cnt_q, sym_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             space_arm_q, space_arm_d;
  logic             vald_d, err_d;
  logic [7:0]       code_d;
  logic [3:0]       len_d;

  // The run counter saturates so an arbitrarily long mark still reads as too long.
  assign run_inc = (run_q == RUN_SAT) ? run_q : run_q + RUN_ONE;

  always_comb begin
    state_d     = state_q;
    run_d       = run_q;
    sym_cnt_d   = sym_cnt_q;
    shift_d     = shift_q;
    space_arm_d = space_arm_q;
    vald_d      = 1'b0;
    err_d       = 1'b0;
    code_d      = charcode_data;
    len_d       = charlen_data;

    case (state_q)
      IDLE: begin
        if (led_in) begin
          state_d = MARK;
          run_d   = RUN_ONE;
        end
      end

      MARK: begin
        if (led_in) begin
          run_d = run_inc;
        end else if (run_q >= RUN_LONG || sym_cnt_q == 4'd8) begin
          err_d     = 1'b1;
          shift_d   = 8'd0;
          sym_cnt_d = 4'd0;
          state_d   = DISCARD;
          run_d     = RUN_ONE;
        end else begin
          shift_d[3'd7 - sym_cnt_q[2:0]] = (run_q >= RUN_DASH);
          sym_cnt_d = sym_cnt_q + 4'd1;
          state_d   = GAP;
          run_d     = RUN_ONE;
        end
      end

      GAP: begin
        if (led_in) begin
          // A mark always beats a gap threshold reached on the same edge.
          state_d = MARK;
          run_d   = RUN_ONE;
        end else begin
          run_d = run_inc;
          if (run_inc == RUN_DASH && sym_cnt_q != 4'd0) begin
            vald_d      = 1'b1;
            code_d      = shift_q;
            len_d       = sym_cnt_q;
            shift_d     = 8'd0;
            sym_cnt_d   = 4'd0;
            space_arm_d = 1'b1;
          end
          if (run_inc == RUN_LONG) begin
            if (space_arm_q) begin
              vald_d      = 1'b1;
              code_d      = 8'd0;
              len_d       = 4'd0;
              space_arm_d = 1'b0;
            end
            state_d = IDLE;
          end
        end
      end

      default: begin
        // DISCARD: swallow the rest of an errored character.
        if (led_in) begin
          run_d = RUN_ONE;
        end else begin
          run_d = run_inc;
          if (run_inc == RUN_DASH) begin
            state_d = IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      run_q         <= '0;
      sym_cnt_q     <= 4'd0;
      shift_q       <= 8'd0;
      space_arm_q   <= 1'b0;
      char_vald     <= 1'b0;
      sym_err       <= 1'b0;
      charcode_data <= 8'd0;
      charlen_data  <= 4'd0;
    end else begin
      state_q       <= state_d;
      run_q         <= run_d;
      sym_cnt_q     <= sym_cnt_d;
      shift_q       <= shift_d;
      space_arm_q   <= space_arm_d;
      char_vald     <= vald_d;
      sym_err       <= err_d;
      charcode_data <= code_d;
      charlen_data  <= len_d;
    end
  end

endmodule

// File: tb/tb_morse_rx.sv
// Bench for morse_rx: two instances (UNIT=1 and UNIT=4) driven with directed Morse
// patterns; expected pulses go into per-instance queues checked by one monitor.
module tb_morse_rx;

  typedef struct {
    bit         err;
    logic [7:0] code;
    logic [3:0] len;
    int         cyc;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       led1 = 1'b0;
  logic       led4 = 1'b0;
  logic       u1_vald, u1_err, u4_vald, u4_err;
  logic [7:0] u1_code, u4_code;
  logic [3:0] u1_len, u4_len;

  exp_t q1[$];
  exp_t q4[$];
  int   cyc = 0;
  int   nvec = 0;
  int   nmis = 0;
  bit   rst_chk = 1'b0;
  bit   done = 1'b0;

  morse_rx #(.UNIT(1), .CNT_W(8)) u_rx1 (
    .clock         (clock),
    .reset         (reset),
    .led_in        (led1),
    .char_vald     (u1_vald),
    .charcode_data (u1_code),
    .charlen_data  (u1_len),
    .sym_err       (u1_err)
  );

  morse_rx #(.UNIT(4), .CNT_W(8)) u_rx4 (
    .clock         (clock),
    .reset         (reset),
    .led_in        (led4),
    .char_vald     (u4_vald),
    .charcode_data (u4_code),
    .charlen_data  (u4_len),
    .sym_err       (u4_err)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    nvec++;
    if (act !== req) begin
      nmis++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic chk_pulse(input string tag, input bit vald, input bit err,
                           input logic [7:0] code, input logic [3:0] len, inout exp_t q[$]);
    exp_t e;
    if (q.size() == 0) begin
      nvec++;
      nmis++;
      $display("FAIL %s_unexpected: got vald=%0b err=%0b code=%08b len=%0d, want no pulse",
               tag, vald, err, code, len);
    end else begin
      e = q.pop_front();
      chk({tag, "_err"}, int'(err), int'(e.err));
      chk({tag, "_cyc"}, cyc, e.cyc);
      if (!e.err) begin
        chk({tag, "_code"}, int'(code), int'(e.code));
        chk({tag, "_len"}, int'(len), int'(e.len));
      end
    end
  endtask

  // Monitor: all comparisons happen here, away from the active edge.
  always @(negedge clock) begin
    if (rst_chk) begin
      chk("rst_u1_vald", int'(u1_vald), 0);
      chk("rst_u1_err", int'(u1_err), 0);
      chk("rst_u1_code", int'(u1_code), 0);
      chk("rst_u1_len", int'(u1_len), 0);
      chk("rst_u4_vald", int'(u4_vald), 0);
      chk("rst_u4_err", int'(u4_err), 0);
      chk("rst_u4_code", int'(u4_code), 0);
      chk("rst_u4_len", int'(u4_len), 0);
    end
    if (u1_vald || u1_err) chk_pulse("u1", u1_vald, u1_err, u1_code, u1_len, q1);
    if (u4_vald || u4_err) chk_pulse("u4", u4_vald, u4_err, u4_code, u4_len, q4);
    if (done) begin
      chk("u1_pending", q1.size(), 0);
      chk("u4_pending", q4.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
    end
  end

  task automatic drive(input bit on4, input bit v, input int n);
    repeat (n) begin
      if (on4) led4 = v;
      else led1 = v;
      @(negedge clock);
    end
  endtask

  task automatic push(input bit on4, input bit err, input logic [7:0] code,
                      input logic [3:0] len, input int at);
    exp_t e;
    e.err = err; e.code = code; e.len = len; e.cyc = at;
    if (on4) q4.push_back(e);
    else q1.push_back(e);
  endtask

  // Send one character, then a gap of gap_units; a gap of 5+ units also yields a space.
  task automatic send_char(input bit on4, input logic [7:0] code, input int len,
                           input int gap_units);
    int u;
    u = on4 ? 4 : 1;
    for (int i = 0; i < len; i++) begin
      drive(on4, 1'b1, code[7-i] ? 3 * u : u);
      if (i < len - 1) drive(on4, 1'b0, u);
    end
    push(on4, 1'b0, code, 4'(len), cyc + 2 * u);
    if (gap_units >= 5) push(on4, 1'b0, 8'h00, 4'd0, cyc + 5 * u);
    drive(on4, 1'b0, gap_units * u);
  endtask

  task automatic pulse_rst_chk();
    @(posedge clock); #1 rst_chk = 1'b1;
    @(posedge clock); #1 rst_chk = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    repeat (3) @(negedge clock);
    reset = 1'b0;
    pulse_rst_chk();

    // Idle line: nothing may be emitted.
    drive(1'b0, 1'b0, 20);

    // 'A' then word gap.
    send_char(1'b0, 8'b0100_0000, 2, 7);
    // 'E' then 7 lows: character, then space 3 cycles later.
    send_char(1'b0, 8'b0000_0000, 1, 7);

    // "M16 TA FATIMA"
    send_char(1'b0, 8'b1100_0000, 2, 3);
    send_char(1'b0, 8'b0111_1000, 5, 3);
    send_char(1'b0, 8'b1000_0000, 5, 7);
    send_char(1'b0, 8'b1000_0000, 1, 3);
    send_char(1'b0, 8'b0100_0000, 2, 7);
    send_char(1'b0, 8'b0010_0000, 4, 3);
    send_char(1'b0, 8'b0100_0000, 2, 3);
    send_char(1'b0, 8'b1000_0000, 1, 3);
    send_char(1'b0, 8'b0000_0000, 2, 3);
    send_char(1'b0, 8'b1100_0000, 2, 3);
    send_char(1'b0, 8'b0100_0000, 2, 7);

    // Over-long mark: error one cycle after the falling edge, no character.
    drive(1'b0, 1'b1, 6);
    push(1'b0, 1'b1, 8'h00, 4'd0, cyc + 1);
    drive(1'b0, 1'b0, 6);

    // Nine dots: overflow error on the ninth, character dropped.
    for (int i = 0; i < 9; i++) begin
      drive(1'b0, 1'b1, 1);
      if (i < 8) drive(1'b0, 1'b0, 1);
    end
    push(1'b0, 1'b1, 8'h00, 4'd0, cyc + 1);
    drive(1'b0, 1'b0, 3);
    send_char(1'b0, 8'b1000_0000, 1, 7);

    // UNIT=4: '.-' with a letter gap, then reset in the middle of a dash.
    send_char(1'b1, 8'b0100_0000, 2, 3);
    drive(1'b1, 1'b1, 6);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    led4 = 1'b0;
    pulse_rst_chk();
    drive(1'b1, 1'b0, 10);
    send_char(1'b1, 8'b0000_0000, 1, 7);

    drive(1'b0, 1'b0, 30);
    done = 1'b1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
